// File: rtl/dp_pkg.sv
// Shared definitions for the pipelined datapath: op codes, default widths and
// the default-width issue/execute stage record.
package dp_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREGS_DEF  = 32;
  localparam int OP_W_DEF   = 7;

  typedef logic [OP_W_DEF-1:0] op_t;

  localparam op_t OP_ADD  = 7'd0;
  localparam op_t OP_SUB  = 7'd1;
  localparam op_t OP_AND  = 7'd2;
  localparam op_t OP_OR   = 7'd3;
  localparam op_t OP_XOR  = 7'd4;
  localparam op_t OP_SLL  = 7'd5;
  localparam op_t OP_SRL  = 7'd6;
  localparam op_t OP_SRA  = 7'd7;
  localparam op_t OP_SLT  = 7'd8;
  localparam op_t OP_SLTU = 7'd9;

  // Stage record at default widths; the top builds the same shape from its parameters.
  typedef struct packed {
    logic                  valid;
    op_t                   op;
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
    logic [DATA_W_DEF-1:0] immed;
    logic                  y_sel;
    logic [ADDR_W_DEF-1:0] addr_d;
    logic                  write;
  } stage_t;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU for the pipelined datapath; unknown op codes yield zero.
module dp_alu
  import dp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;

  assign shamt = b[SH_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      OP_W'(OP_ADD):  result = a + b;
      OP_W'(OP_SUB):  result = a - b;
      OP_W'(OP_AND):  result = a & b;
      OP_W'(OP_OR):   result = a | b;
      OP_W'(OP_XOR):  result = a ^ b;
      OP_W'(OP_SLL):  result = a << shamt;
      OP_W'(OP_SRL):  result = a >> shamt;
      OP_W'(OP_SRA):  result = $signed(a) >>> shamt;
      OP_W'(OP_SLT):  result[0] = $signed(a) < $signed(b);
      OP_W'(OP_SLTU): result[0] = a < b;
      default:        result = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_datapath.sv
// 3-stage register-file + ALU datapath (issue, execute, writeback).
// PIPELINED_DATAPATH_BYPASS_EN selects forwarding; otherwise RAW hazards stall issue.
module pipelined_datapath
  import dp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [DATA_W-1:0] immed,
  input  logic              y_sel,
  input  logic              write,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [DATA_W-1:0] w_out,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr_d,
  output logic              out_write
);

  // Handshake: an op transfers on a rising edge where in_valid && in_ready;
  // in_valid is never required to wait on in_ready, and out_valid has no ready.

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] immed;
    logic              y_sel;
    logic [ADDR_W-1:0] addr_d;
    logic              write;
  } ex_stage_t;

  logic [DATA_W-1:0] regs [NREGS];
  ex_stage_t         ex_q;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] rf_a, rf_b;
  logic [DATA_W-1:0] opnd_a, opnd_b;
  logic              ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;
  logic              fire;

  // Address 0 and addresses beyond the file are hard-wired zero and never written.
  function automatic logic live_addr(input logic [ADDR_W-1:0] addr);
    return (addr != '0) && (int'(addr) < NREGS);
  endfunction

  always_comb begin
    rf_a = '0;
    rf_b = '0;
    if (live_addr(addr_a)) rf_a = regs[addr_a];
    if (live_addr(addr_b)) rf_b = regs[addr_b];
  end

  assign ex_hit_a = ex_q.valid && ex_q.write && live_addr(ex_q.addr_d) && (ex_q.addr_d == addr_a);
  assign ex_hit_b = ex_q.valid && ex_q.write && live_addr(ex_q.addr_d) && (ex_q.addr_d == addr_b);
  assign wb_hit_a = out_valid && out_write && live_addr(out_addr_d) && (out_addr_d == addr_a);
  assign wb_hit_b = out_valid && out_write && live_addr(out_addr_d) && (out_addr_d == addr_b);

`ifdef PIPELINED_DATAPATH_BYPASS_EN
  // Youngest producer wins: EX result, then the value sitting in WB, then the file.
  always_comb begin
    opnd_a = rf_a;
    opnd_b = rf_b;
    if (ex_hit_a)      opnd_a = ex_result;
    else if (wb_hit_a) opnd_a = w_out;
    if (ex_hit_b)      opnd_b = ex_result;
    else if (wb_hit_b) opnd_b = w_out;
  end

  assign in_ready = rst_n;
`else
  logic hazard;

  // The file is not write-through, so a producer in WB still blocks until its edge.
  assign hazard   = in_valid && (ex_hit_a || ex_hit_b || wb_hit_a || wb_hit_b);
  assign opnd_a   = rf_a;
  assign opnd_b   = rf_b;
  assign in_ready = rst_n && !hazard;
`endif

  assign fire = in_valid && in_ready;

  dp_alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .op     (ex_q.op),
    .a      (ex_q.a),
    .b      (ex_q.y_sel ? ex_q.b : ex_q.immed),
    .result (ex_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      ex_q       <= '0;
      out_valid  <= 1'b0;
      a_out      <= '0;
      b_out      <= '0;
      w_out      <= '0;
      out_addr_d <= '0;
      out_write  <= 1'b0;
    end else begin
      if (out_valid && out_write && live_addr(out_addr_d)) regs[out_addr_d] <= w_out;

      ex_q.valid <= fire;
      if (fire) begin
        ex_q.op     <= op;
        ex_q.a      <= opnd_a;
        ex_q.b      <= opnd_b;
        ex_q.immed  <= immed;
        ex_q.y_sel  <= y_sel;
        ex_q.addr_d <= addr_d;
        ex_q.write  <= write;
      end

      out_valid <= ex_q.valid;
      if (ex_q.valid) begin
        a_out      <= ex_q.a;
        b_out      <= ex_q.b;
        w_out      <= ex_result;
        out_addr_d <= ex_q.addr_d;
        out_write  <= ex_q.write;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_datapath.sv
// Directed self-checking bench for pipelined_datapath (default or BYPASS_EN build).
module tb_pipelined_datapath;
  import dp_pkg::*;

  localparam int W = 32;

`ifdef PIPELINED_DATAPATH_BYPASS_EN
  localparam int WB_STALL = 0;
  localparam int EX_STALL = 0;
`else
  localparam int WB_STALL = 1;
  localparam int EX_STALL = 2;
`endif

  typedef struct {
    logic [W-1:0] w;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   d;
    logic         wr;
    int           cyc;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [6:0]   op = '0;
  logic [4:0]   addr_a = '0, addr_b = '0, addr_d = '0;
  logic [W-1:0] immed = '0;
  logic         y_sel = 1'b0, write = 1'b0;
  logic [W-1:0] a_out, b_out, w_out;
  logic         out_valid;
  logic [4:0]   out_addr_d;
  logic         out_write;

  res_t         got_q[$];
  logic [W-1:0] exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;

  // ---- clock / reset ----
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  pipelined_datapath dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .addr_a     (addr_a),
    .addr_b     (addr_b),
    .addr_d     (addr_d),
    .immed      (immed),
    .y_sel      (y_sel),
    .write      (write),
    .a_out      (a_out),
    .b_out      (b_out),
    .w_out      (w_out),
    .out_valid  (out_valid),
    .out_addr_d (out_addr_d),
    .out_write  (out_write)
  );

  // Every WB pulse is recorded with the cycle it was seen in.
  always @(negedge clk) begin
    if (out_valid === 1'b1) got_q.push_back('{w_out, a_out, b_out, out_addr_d, out_write, cyc});
  end

  // ---- driver tasks ----
  task automatic drive(input logic [6:0] o, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic [W-1:0] imm, input logic ys,
                       input logic wr, output int stalls, output int acc);
    @(negedge clk);
    op = o; addr_a = a; addr_b = b; addr_d = d; immed = imm; y_sel = ys; write = wr;
    in_valid = 1'b1;
    stalls = 0;
    #1;
    while (in_ready !== 1'b1 && stalls < 10) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (in_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, stalls);
    end
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, output res_t r);
    int n;
    n = 0;
    while (got_q.size() == 0 && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (got_q.size() == 0) begin
      bad++;
      $display("FAIL %s_no_result: out_valid pulses=0, required 1", tag);
      r = '{default: '0};
    end else begin
      r = got_q.pop_front();
    end
  endtask

  // ---- tests ----
  task automatic test_reset();
    res_t r;
    int   s, c;
    rst_n = 1'b0; in_valid = 1'b1; op = OP_ADD; addr_a = 0; addr_b = 0; addr_d = 5;
    immed = 32'h55; y_sel = 1'b0; write = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if ({w_out, a_out, b_out} !== '0) begin
      bad++; $display("FAIL rst_data: w=%h a=%h b=%h want all 0", w_out, a_out, b_out);
    end
    total++; if ({out_addr_d, out_write} !== '0) begin
      bad++; $display("FAIL rst_ctrl: addr_d=%0d write=%b want 0", out_addr_d, out_write);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    drive(OP_ADD, 5, 0, 0, 0, 0, 0, s, c);
    get_result("rst_read", r);
    total++; if (r.w !== '0) begin bad++; $display("FAIL rst_r5: got %h want 0", r.w); end
  endtask

  task automatic test_basic_add();
    res_t r;
    int   s, c0, c1;
    drive(OP_ADD, 0, 0, 3, 32'h10, 0, 1, s, c0);
    total++; if (s !== 0) begin bad++; $display("FAIL add_stall: got %0d want 0", s); end
    @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_early: out_valid=%b want 0", out_valid); end
    // Reading r3 while the ADD sits in WB exercises the WB-stage hazard.
    drive(OP_ADD, 3, 0, 0, 0, 0, 0, s, c1);
    total++; if (s !== WB_STALL) begin bad++; $display("FAIL add_wb_stall: got %0d want %0d", s, WB_STALL); end
    get_result("add", r);
    total++; if (r.cyc - c0 !== 1) begin bad++; $display("FAIL add_latency: got %0d want 1", r.cyc - c0); end
    total++; if (r.w !== 32'h10) begin bad++; $display("FAIL add_w: got %h want 00000010", r.w); end
    total++; if (r.d !== 5'd3 || r.wr !== 1'b1) begin
      bad++; $display("FAIL add_ctrl: addr_d=%0d write=%b want 3 1", r.d, r.wr);
    end
    get_result("add_rd", r);
    total++; if (r.w !== 32'h10) begin bad++; $display("FAIL add_r3: got %h want 00000010", r.w); end
  endtask

  task automatic test_back_to_back();
    res_t         r, r1;
    logic [W-1:0] e;
    int           s, c1, c2;
    drive(OP_ADD, 0, 0, 1, 32'd5, 0, 1, s, c1);
    drive(OP_ADD, 1, 1, 2, 32'd0, 1, 1, s, c2);
    total++; if (s !== EX_STALL) begin bad++; $display("FAIL b2b_stall: got %0d want %0d", s, EX_STALL); end
    exp_q.push_back(32'h5);
    exp_q.push_back(32'hA);
    r1 = '{default: '0};
    for (int i = 0; i < 2; i++) begin
      get_result("b2b", r);
      e = exp_q.pop_front();
      total++; if (r.w !== e) begin bad++; $display("FAIL b2b_w%0d: got %h want %h", i, r.w, e); end
      if (i == 0) r1 = r;
    end
    total++; if (r.a !== 32'h5 || r.b !== 32'h5) begin
      bad++; $display("FAIL b2b_operands: a=%h b=%h want 5 5", r.a, r.b);
    end
    total++; if (r.cyc - r1.cyc !== EX_STALL + 1) begin
      bad++; $display("FAIL b2b_spacing: got %0d want %0d", r.cyc - r1.cyc, EX_STALL + 1);
    end
  endtask

  task automatic test_forward_priority();
    res_t r;
    int   s, c;
    drive(OP_ADD, 0, 0, 1, 32'd5, 0, 1, s, c);
    drive(OP_ADD, 0, 0, 1, 32'd9, 0, 1, s, c);
    drive(OP_OR, 1, 0, 0, 32'd0, 0, 0, s, c);
    total++; if (s !== EX_STALL) begin bad++; $display("FAIL prio_stall: got %0d want %0d", s, EX_STALL); end
    get_result("prio0", r);
    get_result("prio1", r);
    get_result("prio2", r);
    total++; if (r.w !== 32'd9) begin bad++; $display("FAIL prio_w: got %h want 00000009", r.w); end
  endtask

  task automatic test_zero_reg();
    res_t r;
    int   s, c;
    drive(OP_ADD, 0, 0, 0, 32'hFFFF, 0, 1, s, c);
    drive(OP_ADD, 0, 0, 0, 32'h0, 1, 0, s, c);
    total++; if (s !== 0) begin bad++; $display("FAIL zero_stall: got %0d want 0", s); end
    get_result("zero_wr", r);
    total++; if (r.w !== 32'hFFFF || r.d !== 5'd0) begin
      bad++; $display("FAIL zero_wr: w=%h d=%0d want 0000ffff 0", r.w, r.d);
    end
    get_result("zero_rd", r);
    total++; if ({r.w, r.a, r.b} !== '0) begin
      bad++; $display("FAIL zero_rd: w=%h a=%h b=%h want all 0", r.w, r.a, r.b);
    end
  endtask

  logic [6:0]   t_op  [14] = '{OP_SRA, OP_SLT, OP_SLTU, OP_AND, OP_OR, OP_XOR, OP_SLL,
                                OP_SRL, OP_SRL, OP_SUB, OP_ADD, OP_SLT, OP_SLTU, 7'h7F};
  logic [4:0]   t_a   [14] = '{8, 7, 7, 7, 8, 7, 7, 8, 8, 8, 7, 8, 8, 7};
  logic [W-1:0] t_imm [14] = '{32'd4, 32'd1, 32'd1, 32'hF0F0, 32'd1, 32'hF, 32'h24,
                                32'd4, 32'd31, 32'd1, 32'd2, 32'd1, 32'd1, 32'd1};
  logic [W-1:0] t_exp [14] = '{32'hF8000000, 32'd1, 32'd0, 32'hF0F0, 32'h80000001,
                                32'hFFFFFFF0, 32'hFFFFFFF0, 32'h08000000, 32'd1,
                                32'h7FFFFFFF, 32'd1, 32'd1, 32'd0, 32'd0};

  task automatic test_arith();
    res_t r;
    int   s, c;
    drive(OP_SUB, 0, 0, 7, 32'd1, 0, 1, s, c);
    get_result("sub_edge", r);
    total++; if (r.w !== 32'hFFFFFFFF) begin bad++; $display("FAIL sub_edge: got %h want ffffffff", r.w); end
    drive(OP_ADD, 0, 0, 8, 32'h80000000, 0, 1, s, c);
    get_result("set_r8", r);
    for (int i = 0; i < 14; i++) begin
      drive(t_op[i], t_a[i], 0, 0, t_imm[i], 0, 0, s, c);
      get_result("alu", r);
      total++; if (r.w !== t_exp[i]) begin
        bad++; $display("FAIL alu_%0d op=%0d: got %h want %h", i, t_op[i], r.w, t_exp[i]);
      end
    end
    drive(OP_ADD, 0, 0, 9, 32'h33, 0, 1, s, c);
    drive(7'h7F, 7, 0, 9, 32'd1, 0, 1, s, c);
    drive(OP_ADD, 9, 0, 0, 32'd0, 0, 0, s, c);
    get_result("undef0", r);
    get_result("undef1", r);
    total++; if (r.w !== '0 || r.wr !== 1'b1) begin
      bad++; $display("FAIL undef_op: w=%h write=%b want 0 1", r.w, r.wr);
    end
    get_result("undef_rd", r);
    total++; if (r.w !== '0) begin bad++; $display("FAIL undef_r9: got %h want 0", r.w); end
  endtask

  task automatic test_reset_midflight();
    res_t r;
    int   s, c;
    drive(OP_ADD, 0, 0, 4, 32'd7, 0, 1, s, c);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    total++; if (got_q.size() !== 0) begin
      bad++; $display("FAIL mid_pulse: out_valid pulses=%0d want 0", got_q.size());
      got_q.delete();
    end
    drive(OP_ADD, 4, 7, 0, 32'd0, 0, 0, s, c);
    get_result("mid_rd", r);
    total++; if (r.w !== '0) begin bad++; $display("FAIL mid_r4: got %h want 0", r.w); end
    total++; if (r.b !== '0) begin bad++; $display("FAIL mid_r7: got %h want 0", r.b); end
  endtask

  // ---- sequence and final report ----
  initial begin
    test_reset();
    test_basic_add();
    test_back_to_back();
    test_forward_priority();
    test_zero_reg();
    test_arith();
    test_reset_midflight();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
